// File: rtl/sumi3_graph.sv
// rtl/sumi3_graph.sv - elastic x**n (mod 2^W) compute node for the dataflow graph
//
// Purpose:
//   Accepts one start token together with a base x and a signed exponent n.
//   It then runs an iterative multiply loop and emits one result token, x**n mod 2^W.
//   Any exponent n <= 0 (signed) yields 1.
//
// Configuration macro:
//   FAST_POW_EN
//     defined   : square-and-multiply loop, latency bitlen(n)+1 cycles.
//     undefined : linear loop, latency max(n,0)+1 cycles.
//   Results are identical in both builds.
//
// Ports:
//   clk          in   single clock, posedge
//   rst          in   synchronous, active-high reset
//   start_in     in   start control token (value ignored)
//   start_valid  in   start token + operands valid
//   start_ready  out  block idle and able to accept a start token
//   x_in         in   [W-1:0] base, sampled on the start handshake
//   n_in         in   [W-1:0] signed exponent, sampled on the start handshake
//   end_out      out  [W-1:0] result
//   end_valid    out  result valid, held until end_ready
//   end_ready    in   sink accepts the result
module sumi3_graph #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_in,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] n_in,
  output logic [W-1:0] end_out,
  output logic         end_valid,
  input  logic         end_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOOP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] base_q, base_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] end_out_q, end_out_d;
  logic         end_valid_q, end_valid_d;

  // The token value carries no information; only its handshake matters.
  logic unused_start_in;
  assign unused_start_in = start_in;

  // Products are truncated to W bits, so overflow wraps mod 2^W.
  logic [W-1:0] acc_x_base;
  logic [W-1:0] base_sq;
  assign acc_x_base = acc_q * base_q;
  assign base_sq    = base_q * base_q;

  // A non-positive exponent (signed) means the loop is finished.
  logic cnt_le_zero;
  assign cnt_le_zero = ($signed(cnt_q) <= $signed({W{1'b0}}));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      base_q      <= '0;
      cnt_q       <= '0;
      end_out_q   <= '0;
      end_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      end_out_q   <= end_out_d;
      end_valid_q <= end_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    end_out_d   = end_out_q;
    end_valid_d = end_valid_q;

    unique case (state_q)
      S_IDLE: begin
        // A start_valid that arrives while busy is simply not seen here.
        if (start_valid && !rst) begin
          acc_d   = ONE;
          base_d  = x_in;
          cnt_d   = n_in;
          state_d = S_LOOP;
        end
      end

      S_LOOP: begin
        if (cnt_le_zero) begin
          end_out_d   = acc_q;
          end_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
`ifdef FAST_POW_EN
          // Square-and-multiply. cnt is known positive here, so a logical
          // shift right is the same as halving it.
          if (cnt_q[0]) begin
            acc_d = acc_x_base;
          end
          base_d = base_sq;
          cnt_d  = cnt_q >> 1;
`else
          acc_d = acc_x_base;
          cnt_d = cnt_q - ONE;
`endif
        end
      end

      S_DONE: begin
        if (end_ready) begin
          end_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        end_valid_d = 1'b0;
      end
    endcase
  end

`ifndef FAST_POW_EN
  // The squared base is only needed by the fast loop.
  logic [W-1:0] unused_base_sq;
  assign unused_base_sq = base_sq;
`endif

  assign start_ready = (state_q == S_IDLE) && !rst;
  assign end_out     = end_out_q;
  assign end_valid   = end_valid_q;

endmodule

// File: tb/tb_sumi3_graph.sv
// tb/tb_sumi3_graph.sv - self-checking bench for sumi3_graph
module tb_sumi3_graph;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] x_in;
  logic [31:0] n_in;
  logic [31:0] end_out;
  logic        end_valid;
  logic        end_ready;

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  logic [31:0] sb[$];

  sumi3_graph #(.W(32)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .start_valid(start_valid),
    .start_ready(start_ready), .x_in(x_in), .n_in(n_in), .end_out(end_out),
    .end_valid(end_valid), .end_ready(end_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pow_model(input logic [31:0] x, input logic [31:0] n);
    logic [31:0] r;
    r = 32'd1;
    if ($signed(n) > 0) begin
      for (int i = 0; i < int'(n); i++) r = r * x;
    end
    return r;
  endfunction

  function automatic int lat_model(input logic [31:0] n);
    int b;
    if ($signed(n) <= 0) return 1;
`ifdef FAST_POW_EN
    b = 0;
    for (int i = 0; i < 32; i++) if (n[i]) b = i + 1;
    return b + 1;
`else
    return int'(n) + 1;
`endif
  endfunction

  // Scoreboard push on every accepted start token.
  always @(posedge clk) begin
    if (!rst && start_valid && start_ready) begin
      sb.push_back(pow_model(x_in, n_in));
      accepts++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pop_sb(input string tag);
    logic [31:0] v;
    chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      v = sb.pop_front();
      chk({tag, "_sb"}, end_out, v);
    end
  endtask

  task automatic wait_ready(input string tag);
    int w;
    w = 0;
    while (!start_ready && w < 100) begin tick; w++; end
    chk({tag, "_ready"}, 32'(start_ready), 32'd1);
  endtask

  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (!end_valid && lat < 6000) begin tick; lat++; end
    chk({tag, "_valid"}, 32'(end_valid), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] n,
                        input logic [31:0] exp);
    int lat;
    start_valid = 1'b1; x_in = x; n_in = n;
    wait_ready(tag);
    tick;
    start_valid = 1'b0;
    wait_valid(tag, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(lat_model(n)));
    chk({tag, "_out"}, end_out, exp);
    pop_sb(tag);
    tick;
    chk({tag, "_vdrop"}, 32'(end_valid), 32'd0);
    chk({tag, "_idle"}, 32'(start_ready), 32'd1);
  endtask

  initial begin
    int lat, a0, seen;
    logic [31:0] rx, rn;
    rst = 1'b1; start_in = 1'b0; start_valid = 1'b0;
    x_in = '0; n_in = '0; end_ready = 1'b1;
    tick; tick;
    chk("rst_valid", 32'(end_valid), 32'd0);
    chk("rst_out", end_out, 32'd0);
    chk("rst_ready", 32'(start_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(start_ready), 32'd1);

    run_op("x2n3", 32'd2, 32'd3, 32'h0000_0008);
    run_op("x5n0", 32'd5, 32'd0, 32'd1);
    run_op("x7nm1", 32'd7, 32'hFFFF_FFFF, 32'd1);
    run_op("x0n0", 32'd0, 32'd0, 32'd1);
    run_op("x3n20", 32'd3, 32'd20, 32'hCFD4_1B91);
    run_op("x2n32", 32'd2, 32'd32, 32'd0);
    run_op("xffn3", 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF);

    // start_valid held across two cycles: only one accept.
    a0 = accepts;
    start_valid = 1'b1; x_in = 32'd2; n_in = 32'd5;
    wait_ready("hold");
    tick;
    chk("hold_busy1", 32'(start_ready), 32'd0);
    tick;
    chk("hold_busy2", 32'(start_ready), 32'd0);
    start_valid = 1'b0;
    wait_valid("hold", lat);
    chk("hold_accepts", 32'(accepts - a0), 32'd1);
    chk("hold_out", end_out, 32'd32);
    pop_sb("hold");
    tick;
    chk("hold_idle", 32'(start_ready), 32'd1);

    // Back-pressure at DONE.
    end_ready = 1'b0;
    start_valid = 1'b1; x_in = 32'd3; n_in = 32'd4;
    wait_ready("stall");
    tick;
    start_valid = 1'b0;
    wait_valid("stall", lat);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("stall_valid", 32'(end_valid), 32'd1);
      chk("stall_out", end_out, 32'd81);
      chk("stall_busy", 32'(start_ready), 32'd0);
    end
    pop_sb("stall");
    end_ready = 1'b1;
    tick;
    chk("stall_vdrop", 32'(end_valid), 32'd0);
    chk("stall_idle", 32'(start_ready), 32'd1);

    // Reset in the middle of the loop aborts the computation.
    start_valid = 1'b1; x_in = 32'd3; n_in = 32'd100;
    wait_ready("abort");
    tick;
    start_valid = 1'b0;
    tick; tick;
    rst = 1'b1;
    #1;
    chk("abort_rst_ready", 32'(start_ready), 32'd0);
    tick;
    chk("abort_valid", 32'(end_valid), 32'd0);
    chk("abort_out", end_out, 32'd0);
    rst = 1'b0;
    sb.delete();
    seen = 0;
    for (int i = 0; i < 120; i++) begin
      if (end_valid) seen++;
      tick;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    run_op("after_abort", 32'd2, 32'd10, 32'h0000_0400);

    // Random operands; mostly short exponents to keep the run short.
    for (int i = 0; i < 100; i++) begin
      rx = $urandom;
      if ($urandom_range(0, 9) == 0) rn = 32'($urandom_range(0, 4000));
      else rn = 32'($signed($urandom_range(0, 72)) - 8);
      run_op("rand", rx, rn, pow_model(rx, rn));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
